// File: rtl/mac_accum_requant.sv
// Accumulates N signed MAC products, then rounds half-up, shifts and saturates
// the sum to WLQ bits behind a one-entry valid/ready output slot.
module mac_accum_requant #(
    parameter int WLIN  = 17,
    parameter int N     = 4,
    parameter int WLACC = 24,
    parameter int SHIFT = 6,
    parameter int WLQ   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    input  logic signed [WLIN-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic signed [WLQ-1:0]  out_data,
    output logic                   out_sat,
    input  logic                   out_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Two guard bits: one for the final add, one so the rounding offset cannot overflow.
    localparam int WS = WLACC + 2;
    localparam logic signed [WS-1:0] HALF = WS'(1) <<< (SHIFT - 1);
    localparam logic signed [WS-1:0] QMAX = {{(WS-WLQ+1){1'b0}}, {(WLQ-1){1'b1}}};
    localparam logic signed [WS-1:0] QMIN = {{(WS-WLQ+1){1'b1}}, {(WLQ-1){1'b0}}};

    logic signed [WLACC-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic signed [WLQ-1:0]   data_q, data_d;
    logic                    sat_q, sat_d;

    logic                    last;
    logic                    accept;
    logic signed [WS-1:0]    sum;
    logic signed [WS-1:0]    rnd;
    logic signed [WS-1:0]    r;
    logic                    clip;
    logic signed [WLQ-1:0]   q;

    assign last     = (cnt_q == CW'(N - 1));
    assign in_ready = !last || !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;

    always_comb begin
        sum  = WS'(acc_q) + WS'(in_data);
        rnd  = sum + HALF;
        r    = rnd >>> SHIFT;
        clip = (r > QMAX) || (r < QMIN);
        q    = clip ? {r[WS-1], {(WLQ-1){~r[WS-1]}}} : r[WLQ-1:0];
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        sat_d   = sat_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (last) begin
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                data_d  = q;
                sat_d   = clip;
            end else begin
                acc_d = acc_q + WLACC'(in_data);
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

endmodule
